// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp encodings, monitor states and error codes
package traffic_pkg;

    // Lamp sample is {red, yellow, green}
    localparam logic [2:0] RED_ONLY    = 3'b100;
    localparam logic [2:0] YELLOW_ONLY = 3'b010;
    localparam logic [2:0] GREEN_ONLY  = 3'b001;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_ONEHOT = 3'd1;
    localparam logic [2:0] ERR_ORDER  = 3'd2;
    localparam logic [2:0] ERR_SHORT  = 3'd3;
    localparam logic [2:0] ERR_LONG   = 3'd4;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_RED    = 2'd1,
        ST_GREEN  = 2'd2,
        ST_YELLOW = 2'd3
    } state_t;

    // True when exactly one of the three lamps is lit
    function automatic logic lamp_onehot(input logic [2:0] lamp);
        return (lamp == RED_ONLY) || (lamp == YELLOW_ONLY) || (lamp == GREEN_ONLY);
    endfunction

    // Lamp pattern that belongs to a tracked phase; SYNC has none
    function automatic logic [2:0] phase_lamp(input state_t st);
        case (st)
            ST_RED:    return RED_ONLY;
            ST_GREEN:  return GREEN_ONLY;
            ST_YELLOW: return YELLOW_ONLY;
            default:   return 3'b000;
        endcase
    endfunction

    // Legal successor phase: red -> green -> yellow -> red
    function automatic state_t next_phase(input state_t st);
        case (st)
            ST_RED:    return ST_GREEN;
            ST_GREEN:  return ST_YELLOW;
            ST_YELLOW: return ST_RED;
            default:   return ST_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive one-hot, order and dwell checker for traffic lamps
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int RED_CYC    = 5,
    parameter int GREEN_CYC  = 4,
    parameter int YELLOW_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    output logic       locked,
    output logic       err,
    output logic [2:0] err_code,
    output logic       err_sticky,
    output logic [7:0] cycles
);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_prev;
    logic       r_locked;
    logic       r_err;
    logic [2:0] r_err_code;
    logic       r_err_sticky;
    logic [7:0] r_cycles;

    logic [2:0] w_lamp;
    logic [7:0] w_dwell;
    logic [8:0] w_cnt_inc;
    state_t     w_state_nx;
    logic [7:0] w_cnt_nx;
    logic       w_locked_nx;
    logic       w_err_nx;
    logic [2:0] w_err_code_nx;
    logic       w_err_sticky_nx;
    logic [7:0] w_cycles_nx;
    logic       w_fire;
    logic [2:0] w_fire_code;

    assign w_lamp    = {red, yellow, green};
    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

    // Required dwell for the phase currently being tracked
    always_comb begin
        w_dwell = 8'd0;
        case (r_state)
            ST_RED:    w_dwell = 8'(RED_CYC);
            ST_GREEN:  w_dwell = 8'(GREEN_CYC);
            ST_YELLOW: w_dwell = 8'(YELLOW_CYC);
            default:   w_dwell = 8'd0;
        endcase
    end

    // Next-state and check logic; checks are in priority order and any error drops back to SYNC
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_locked_nx     = r_locked;
        w_err_nx        = 1'b0;
        w_err_code_nx   = r_err_code;
        w_err_sticky_nx = r_err_sticky;
        w_cycles_nx     = r_cycles;
        w_fire          = 1'b0;
        w_fire_code     = ERR_NONE;

        if (r_state == ST_SYNC) begin
            // Only a fresh not-red to red edge starts tracking
            if (w_lamp == RED_ONLY && r_prev != RED_ONLY) begin
                w_state_nx  = ST_RED;
                w_cnt_nx    = 8'd1;
                w_locked_nx = 1'b1;
            end
        end else if (!lamp_onehot(w_lamp)) begin
            w_fire      = 1'b1;
            w_fire_code = ERR_ONEHOT;
        end else if (w_lamp == phase_lamp(r_state)) begin
            if (w_cnt_inc > {1'b0, w_dwell}) begin
                w_fire      = 1'b1;
                w_fire_code = ERR_LONG;
            end else begin
                w_cnt_nx = w_cnt_inc[7:0];
            end
        end else if (w_lamp == phase_lamp(next_phase(r_state))) begin
            if (r_cnt != w_dwell) begin
                w_fire      = 1'b1;
                w_fire_code = ERR_SHORT;
            end else begin
                w_state_nx = next_phase(r_state);
                w_cnt_nx   = 8'd1;
                if (r_state == ST_YELLOW) begin
                    w_cycles_nx = r_cycles + 8'd1;
                end
            end
        end else begin
            w_fire      = 1'b1;
            w_fire_code = ERR_ORDER;
        end

        if (w_fire) begin
            w_err_nx        = 1'b1;
            w_err_code_nx   = w_fire_code;
            w_err_sticky_nx = 1'b1;
            w_locked_nx     = 1'b0;
            w_state_nx      = ST_SYNC;
            w_cnt_nx        = 8'd0;
        end
    end

    // State, previous sample and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_SYNC;
            r_cnt        <= 8'd0;
            r_prev       <= 3'b000;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_sticky <= 1'b0;
            r_cycles     <= 8'd0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_prev       <= w_lamp;
            r_locked     <= w_locked_nx;
            r_err        <= w_err_nx;
            r_err_code   <= w_err_code_nx;
            r_err_sticky <= w_err_sticky_nx;
            r_cycles     <= w_cycles_nx;
        end
    end

    assign locked     = r_locked;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign err_sticky = r_err_sticky;
    assign cycles     = r_cycles;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] RY  = 3'b110;

    logic       clk;
    logic       reset;
    logic       red;
    logic       yellow;
    logic       green;
    logic       locked;
    logic       err;
    logic [2:0] err_code;
    logic       err_sticky;
    logic [7:0] cycles;

    int n_pass;
    int n_total;
    logic err_acc;

    traffic_light_monitor #(
        .RED_CYC    (5),
        .GREEN_CYC  (4),
        .YELLOW_CYC (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .locked     (locked),
        .err        (err),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .cycles     (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Apply one lamp sample, let one rising edge take it, settle 1 ns past the edge
    task automatic drive(input logic [2:0] l, input int n);
        for (int k = 0; k < n; k++) begin
            {red, yellow, green} = l;
            @(posedge clk);
            #1;
            err_acc = err_acc | err;
        end
    endtask

    task automatic do_reset();
        {red, yellow, green} = 3'b000;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        err_acc = 1'b0;
    endtask

    task automatic run_cycle();
        drive(R, 5);
        drive(G, 4);
        drive(Y, 2);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        err_acc = 1'b0;
        reset   = 1'b0;
        {red, yellow, green} = 3'b000;

        // Reset state
        #2;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_cycles", cycles, 0);
        #4;
        reset = 1'b1;

        // Nominal: three legal cycles then red
        drive(R, 1);
        chk("nom_first_lock", locked, 1);
        drive(R, 4);
        drive(G, 4);
        drive(Y, 2);
        chk("nom_cyc0", cycles, 0);
        for (int i = 1; i < 3; i++) begin
            run_cycle();
            chk("nom_cyc", cycles, i);
        end
        drive(R, 1);
        chk("nom_cycles", cycles, 3);
        chk("nom_locked", locked, 1);
        chk("nom_no_err", err_acc, 0);
        chk("nom_code", err_code, 0);
        chk("nom_sticky", err_sticky, 0);

        // Short green
        do_reset();
        drive(R, 5);
        drive(G, 3);
        chk("short_pre_err", err_acc, 0);
        drive(Y, 1);
        chk("short_err", err, 1);
        chk("short_code", err_code, 3);
        chk("short_locked", locked, 0);
        chk("short_sticky", err_sticky, 1);
        drive(Y, 1);
        chk("short_err_drop", err, 0);
        chk("short_still_unlocked", locked, 0);
        drive(R, 1);
        chk("short_relock", locked, 1);
        err_acc = 1'b0;
        drive(R, 4);
        drive(G, 4);
        drive(Y, 2);
        drive(R, 1);
        chk("short_cycles", cycles, 1);
        chk("short_no_new_err", err_acc, 0);
        chk("short_code_held", err_code, 3);
        chk("short_sticky_held", err_sticky, 1);

        // Stuck red
        do_reset();
        drive(R, 5);
        chk("long_pre_err", err_acc, 0);
        drive(R, 1);
        chk("long_err", err, 1);
        chk("long_code", err_code, 4);
        chk("long_locked", locked, 0);
        err_acc = 1'b0;
        drive(R, 3);
        chk("long_no_relock", locked, 0);
        chk("long_no_more_err", err_acc, 0);

        // Double lamp
        do_reset();
        drive(R, 3);
        drive(RY, 1);
        chk("onehot_err", err, 1);
        chk("onehot_code", err_code, 1);
        chk("onehot_locked", locked, 0);
        drive(R, 1);
        chk("onehot_resync", locked, 1);
        chk("onehot_err_drop", err, 0);

        // Order violation
        do_reset();
        drive(R, 5);
        drive(Y, 1);
        chk("order_err", err, 1);
        chk("order_code", err_code, 2);
        chk("order_locked", locked, 0);

        // Async reset mid-green
        do_reset();
        run_cycle();
        drive(R, 5);
        drive(G, 2);
        chk("arst_pre_cycles", cycles, 1);
        chk("arst_pre_locked", locked, 1);
        {red, yellow, green} = R;
        reset = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_cycles", cycles, 0);
        chk("arst_err", err, 0);
        chk("arst_code", err_code, 0);
        chk("arst_sticky", err_sticky, 0);
        reset = 1'b1;
        drive(R, 1);
        chk("arst_relock", locked, 1);

        // Wrap after 256 legal cycles
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_cycle();
            if (i == 255) chk("wrap_255", cycles, 255);
        end
        drive(R, 1);
        chk("wrap_cycles", cycles, 0);
        chk("wrap_sticky", err_sticky, 0);
        chk("wrap_no_err", err_acc, 0);
        chk("wrap_locked", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
